// File: rtl/fsk_frame_ctrl.sv
// fsk_frame_ctrl: transmit sequencer for a CPFSK NCO modulator.
// Wraps streamed payload bytes into preamble / sync / payload / guard.
// Drives the per-bit modulation data and the matching signed frequency offset.
// Optional build macro FSK_PARITY_EN appends an even-parity bit after every payload byte.
module fsk_frame_ctrl #(
    parameter int unsigned CLK_DIV       = 10000,
    parameter int unsigned PREAMBLE_BITS = 16,
    parameter logic [7:0]  SYNC_WORD     = 8'hD3,
    parameter int unsigned GUARD_BITS    = 4,
    parameter logic [24:0] DF_WORD       = 25'd8388
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               bit_out,
    output logic signed [24:0] freq_df,
    output logic               mod_en,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam int unsigned TCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned MAX_PG  = (PREAMBLE_BITS > GUARD_BITS) ? PREAMBLE_BITS : GUARD_BITS;
    localparam int unsigned BIT_MAX = (MAX_PG > 8) ? MAX_PG : 8;
    localparam int unsigned BCW     = $clog2(BIT_MAX);

    localparam logic [TCW-1:0]     TICK_LAST  = TCW'(CLK_DIV - 1);
    localparam logic [TCW-1:0]     TICK_PRE   = TCW'(CLK_DIV - 2);
    localparam logic [BCW-1:0]     PRE_LAST   = BCW'(PREAMBLE_BITS - 1);
    localparam logic [BCW-1:0]     GUARD_LAST = BCW'(GUARD_BITS - 1);
    localparam logic [BCW-1:0]     BYTE_LAST  = BCW'(7);
    localparam logic signed [24:0] DF_POS     = DF_WORD;
    localparam logic signed [24:0] DF_NEG     = -DF_WORD;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSync,
        StData,
        StGuard
`ifdef FSK_PARITY_EN
        , StParity
`endif
    } state_t;

    state_t              r_state;
    logic [TCW-1:0]      r_tick_cnt;
    logic [BCW-1:0]      r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_data;
    logic                r_last;
`ifdef FSK_PARITY_EN
    logic                r_parity;
`endif
    logic                r_s_ready;
    logic                r_bit_out;
    logic signed [24:0]  r_freq_df;
    logic                r_mod_en;
    logic                r_busy;
    logic                r_done;
    logic                r_underrun;

    logic                w_tick;
    logic                w_byte_end;
    logic                w_ready_soon;

    // Bit-period strobe, end-of-byte strobe and one-cycle-early warning for the ready window.
    always_comb begin
        w_tick = (r_tick_cnt == TICK_LAST);
`ifdef FSK_PARITY_EN
        w_byte_end   = w_tick && (r_state == StParity);
        w_ready_soon = (r_state == StParity) && (r_tick_cnt == TICK_PRE) && !r_last;
`else
        w_byte_end   = w_tick && (r_state == StData) && (r_bit_cnt == BYTE_LAST);
        w_ready_soon = (r_state == StData) && (r_bit_cnt == BYTE_LAST) &&
                       (r_tick_cnt == TICK_PRE) && !r_last;
`endif
    end

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
`ifdef FSK_PARITY_EN
            r_parity   <= 1'b0;
`endif
            r_s_ready  <= 1'b0;
            r_bit_out  <= 1'b1;
            r_freq_df  <= DF_POS;
            r_mod_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            // Ready is registered, so it is raised one cycle ahead of the byte-ending tick.
            r_s_ready <= w_ready_soon;

            if (r_state == StIdle || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TCW'(1);
            end

            case (r_state)
                StIdle: begin
                    r_s_ready <= 1'b1;
                    if (s_valid && r_s_ready) begin
                        r_data     <= s_data;
                        r_last     <= s_last;
                        r_underrun <= 1'b0;
                        r_s_ready  <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_bit_out  <= 1'b1;
                        r_freq_df  <= DF_POS;
                        r_mod_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StPre;
                    end
                end
                StPre: begin
                    if (w_tick) begin
                        if (r_bit_cnt == PRE_LAST) begin
                            r_bit_cnt <= '0;
                            r_shift   <= {SYNC_WORD[6:0], 1'b0};
                            r_bit_out <= SYNC_WORD[7];
                            r_freq_df <= SYNC_WORD[7] ? DF_POS : DF_NEG;
                            r_state   <= StSync;
                        end else begin
                            // Preamble alternates starting from 1.
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_bit_out <= ~r_bit_out;
                            r_freq_df <= r_bit_out ? DF_NEG : DF_POS;
                        end
                    end
                end
                StSync: begin
                    if (w_tick) begin
                        if (r_bit_cnt == BYTE_LAST) begin
                            r_bit_cnt <= '0;
                            r_shift   <= {r_data[6:0], 1'b0};
                            r_bit_out <= r_data[7];
                            r_freq_df <= r_data[7] ? DF_POS : DF_NEG;
`ifdef FSK_PARITY_EN
                            r_parity  <= ^r_data;
`endif
                            r_state   <= StData;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_out <= r_shift[7];
                            r_freq_df <= r_shift[7] ? DF_POS : DF_NEG;
                        end
                    end
                end
                StData: begin
                    if (w_tick && (r_bit_cnt != BYTE_LAST)) begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_out <= r_shift[7];
                        r_freq_df <= r_shift[7] ? DF_POS : DF_NEG;
                    end
`ifdef FSK_PARITY_EN
                    else if (w_tick) begin
                        r_bit_out <= r_parity;
                        r_freq_df <= r_parity ? DF_POS : DF_NEG;
                        r_state   <= StParity;
                    end
`endif
                end
                StGuard: begin
                    if (w_tick) begin
                        if (r_bit_cnt == GUARD_LAST) begin
                            r_bit_cnt <= '0;
                            r_done    <= 1'b1;
                            r_mod_en  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end
                end
`ifdef FSK_PARITY_EN
                StParity: begin
                    // Leaving this state is handled by the byte-boundary logic below.
                end
`endif
                default: r_state <= StIdle;
            endcase

            // Byte boundary: chain the next byte seamlessly, or close the frame into the guard.
            if (w_byte_end) begin
                r_bit_cnt <= '0;
                if (!r_last && s_valid && r_s_ready) begin
                    r_shift   <= {s_data[6:0], 1'b0};
                    r_bit_out <= s_data[7];
                    r_freq_df <= s_data[7] ? DF_POS : DF_NEG;
                    r_last    <= s_last;
`ifdef FSK_PARITY_EN
                    r_parity  <= ^s_data;
`endif
                    r_state   <= StData;
                end else begin
                    if (!r_last) begin
                        r_underrun <= 1'b1;
                    end
                    r_bit_out <= 1'b1;
                    r_freq_df <= DF_POS;
                    r_state   <= StGuard;
                end
            end
        end
    end

    assign s_ready  = r_s_ready;
    assign bit_out  = r_bit_out;
    assign freq_df  = r_freq_df;
    assign mod_en   = r_mod_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign underrun = r_underrun;

endmodule
